prt_ingress_writer: RTL and testbench

//  Upstream feeder for the PRT frame buffer. Takes a byte stream with valid/ready/last
//  and drives the PRT write methods (start_writing, write, finish_writing) for each frame.

---
 rtl/prt_ingress_writer.sv | 115 +++++++++++
 tb/tb_prt_ingress_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_ingress_writer.sv
// Byte-stream front end for the PRT frame buffer: drives start/write/finish
// per frame, clips frames at MAX_BYTES and hands a descriptor downstream.
module prt_ingress_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 2000,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  prt_start_rdy,
    output logic                  prt_start_en,
    input  logic                  prt_start_slot,
    input  logic                  prt_write_rdy,
    output logic                  prt_write_en,
    output logic [DATA_WIDTH-1:0] prt_write_data,
    input  logic                  prt_finish_rdy,
    output logic                  prt_finish_en,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic                  desc_slot,
    output logic [CNT_WIDTH-1:0]  desc_len,
    output logic                  desc_oversize,
    output logic [CNT_WIDTH-1:0]  stat_frames,
    output logic [CNT_WIDTH-1:0]  stat_oversize
);

    typedef enum logic [2:0] {
        IDLE, START, STREAM, FINISH, DESC
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIM = CNT_WIDTH'(MAX_BYTES);

    state_t               r_state;
    logic                 r_slot;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_frames;
    logic [CNT_WIDTH-1:0] r_ovcnt;

    logic w_stream;
    logic w_accept;
    logic w_room;

    assign w_stream = (r_state == STREAM);
    assign w_room   = (r_len < LIM);
    assign w_accept = w_stream && s_valid && prt_write_rdy;

    // Gated by RST_N so the start strobe is low while reset is held.
    assign prt_start_en   = RST_N && (r_state == IDLE)
                            && s_valid && prt_start_rdy;
    assign s_ready        = w_stream && prt_write_rdy;
    assign prt_write_en   = w_accept && w_room;
    assign prt_write_data = w_stream ? s_data : '0;
    assign prt_finish_en  = (r_state == FINISH) && prt_finish_rdy;

    assign desc_valid    = (r_state == DESC);
    assign desc_slot     = r_slot;
    assign desc_len      = r_len;
    assign desc_oversize = r_ovf;
    assign stat_frames   = r_frames;
    assign stat_oversize = r_ovcnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_slot   <= 1'b0;
            r_ovf    <= 1'b0;
            r_len    <= '0;
            r_frames <= '0;
            r_ovcnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (s_valid && prt_start_rdy)
                        r_state <= START;
                end
                START: begin
                    if (prt_write_rdy) begin
                        r_slot  <= prt_start_slot;
                        r_len   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (w_room)
                            r_len <= r_len + 1'b1;
                        else
                            r_ovf <= 1'b1;
                        if (s_last)
                            r_state <= FINISH;
                    end
                end
                FINISH: begin
                    if (prt_finish_rdy)
                        r_state <= DESC;
                end
                DESC: begin
                    if (desc_ready) begin
                        r_frames <= r_frames + 1'b1;
                        r_ovcnt  <= r_ovcnt + CNT_WIDTH'(r_ovf);
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Bench for prt_ingress_writer: frame table plus reset, back-pressure and
// descriptor-stall sequences, with a write/descriptor scoreboard.
module tb_prt_ingress_writer;

    localparam int MAXB = 4;

    logic        CLK = 0;
    logic        RST_N = 0;
    logic        s_valid = 0;
    logic [7:0]  s_data = 0;
    logic        s_last = 0;
    logic        s_ready;
    logic        prt_start_rdy = 1;
    logic        prt_start_en;
    logic        prt_start_slot = 0;
    logic        prt_write_rdy = 1;
    logic        prt_write_en;
    logic [7:0]  prt_write_data;
    logic        prt_finish_rdy = 1;
    logic        prt_finish_en;
    logic        desc_valid;
    logic        desc_ready = 1;
    logic        desc_slot;
    logic [15:0] desc_len;
    logic        desc_oversize;
    logic [15:0] stat_frames;
    logic [15:0] stat_oversize;

    prt_ingress_writer #(
        .DATA_WIDTH(8), .MAX_BYTES(MAXB), .CNT_WIDTH(16)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready),
        .prt_start_rdy(prt_start_rdy), .prt_start_en(prt_start_en),
        .prt_start_slot(prt_start_slot),
        .prt_write_rdy(prt_write_rdy), .prt_write_en(prt_write_en),
        .prt_write_data(prt_write_data),
        .prt_finish_rdy(prt_finish_rdy), .prt_finish_en(prt_finish_en),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_slot(desc_slot), .desc_len(desc_len),
        .desc_oversize(desc_oversize),
        .stat_frames(stat_frames), .stat_oversize(stat_oversize)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic slot;
        int   len;
        logic ovs;
    } desc_t;

    typedef struct {
        int         n;
        logic       slot;
        logic [7:0] base;
        int         elen;
        logic       eovs;
    } vec_t;

    logic [7:0] wq[$];
    desc_t      dq[$];
    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_fin = 0;
    int exp_frames = 0;
    int exp_ovs = 0;
    bit rnd = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (rnd) begin
            prt_write_rdy  = ($urandom_range(0, 3) != 0);
            prt_finish_rdy = ($urandom_range(0, 1) != 0);
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            if (prt_start_en) n_start++;
            if (prt_finish_en) n_fin++;
            if (prt_start_en || prt_write_en || prt_finish_en)
                chk("en_onehot", 64'(int'(prt_start_en) + int'(prt_write_en)
                    + int'(prt_finish_en)), 64'd1);
            if (prt_write_en) begin
                if (wq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_unexpected: got %0h expected none",
                             prt_write_data);
                end else begin
                    chk("wr_data", 64'(prt_write_data), 64'(wq.pop_front()));
                end
            end
            if (desc_valid && desc_ready) begin
                if (dq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL desc_unexpected: got len %0d expected none",
                             desc_len);
                end else begin
                    desc_t d;
                    d = dq.pop_front();
                    chk("desc_slot", 64'(desc_slot), 64'(d.slot));
                    chk("desc_len", 64'(desc_len), 64'(d.len));
                    chk("desc_ovs", 64'(desc_oversize), 64'(d.ovs));
                    exp_frames++;
                    exp_ovs += int'(d.ovs);
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic last);
        s_valid = 1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (s_ready) begin
                @(posedge CLK);
                #1;
                s_valid = 0;
                s_last  = 0;
                return;
            end
        end
        chk("word_timeout", 64'd1, 64'd0);
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic send_frame(input int n, input logic slot,
                              input logic [7:0] base, input int elen,
                              input logic eovs);
        prt_start_slot = slot;
        for (int i = 0; i < n; i++)
            if (i < MAXB) wq.push_back(base + 8'(17 * i));
        dq.push_back('{slot, elen, eovs});
        for (int i = 0; i < n; i++)
            send_word(base + 8'(17 * i), i == n - 1);
    endtask

    task automatic wait_desc();
        int k;
        k = 0;
        while (dq.size() != 0 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        if (dq.size() != 0) chk("desc_timeout", 64'(dq.size()), 64'd0);
        @(posedge CLK);
        #1;
        chk("stat_frames", 64'(stat_frames), 64'(exp_frames));
        chk("stat_ovs", 64'(stat_oversize), 64'(exp_ovs));
        chk("wq_drained", 64'(wq.size()), 64'd0);
    endtask

    task automatic do_reset();
        #2 RST_N = 0;
        #1;
        chk("reset_outs", 64'({s_ready, prt_start_en, prt_write_en,
            prt_write_data, prt_finish_en, desc_valid, desc_slot,
            desc_len, desc_oversize, stat_frames, stat_oversize}), 64'd0);
        wq.delete();
        dq.delete();
        exp_frames = 0;
        exp_ovs = 0;
        s_valid = 0;
        s_last = 0;
        #10 RST_N = 1;
        @(posedge CLK);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        int bad, s0, f0;
        logic [15:0] l0;
        logic sl0;

        vt[0] = '{4, 1'b0, 8'hAA, 4, 1'b0};
        vt[1] = '{1, 1'b1, 8'h10, 1, 1'b0};
        vt[2] = '{6, 1'b0, 8'h20, 4, 1'b1};
        vt[3] = '{5, 1'b1, 8'h30, 4, 1'b1};
        vt[4] = '{3, 1'b1, 8'h40, 3, 1'b0};
        vt[5] = '{2, 1'b0, 8'h50, 2, 1'b0};

        s_valid = 1;
        #3;
        chk("reset_outs0", 64'({s_ready, prt_start_en, prt_write_en,
            prt_write_data, prt_finish_en, desc_valid, desc_slot,
            desc_len, desc_oversize, stat_frames, stat_oversize}), 64'd0);
        s_valid = 0;
        #20 RST_N = 1;
        @(posedge CLK);
        #1;
        rnd = 1;

        for (int v = 0; v < 6; v++) begin
            s0 = n_start;
            f0 = n_fin;
            send_frame(vt[v].n, vt[v].slot, vt[v].base,
                       vt[v].elen, vt[v].eovs);
            wait_desc();
            chk("start_pulses", 64'(n_start - s0), 64'd1);
            chk("finish_pulses", 64'(n_fin - f0), 64'd1);
        end

        prt_start_rdy = 0;
        fork
            send_frame(3, 1'b0, 8'h60, 3, 1'b0);
            begin
                bad = 0;
                repeat (100) begin
                    @(negedge CLK);
                    if (s_ready || prt_start_en || prt_write_en
                        || prt_finish_en) bad++;
                end
                chk("t3_backpressure", 64'(bad), 64'd0);
                prt_start_rdy = 1;
            end
        join
        wait_desc();

        desc_ready = 0;
        send_frame(2, 1'b1, 8'h70, 2, 1'b0);
        fork
            send_frame(1, 1'b0, 8'h80, 1, 1'b0);
            begin
                for (int i = 0; i < 50 && !desc_valid; i++)
                    @(negedge CLK);
                l0 = desc_len;
                sl0 = desc_slot;
                bad = 0;
                repeat (10) begin
                    @(negedge CLK);
                    if (!desc_valid || desc_len != l0 || desc_slot != sl0
                        || s_ready || prt_start_en) bad++;
                end
                chk("t5_hold", 64'(bad), 64'd0);
                desc_ready = 1;
            end
        join
        wait_desc();

        prt_start_slot = 1;
        wq.push_back(8'h90);
        wq.push_back(8'hA1);
        send_word(8'h90, 0);
        send_word(8'hA1, 0);
        f0 = n_fin;
        do_reset();
        repeat (5) @(negedge CLK);
        chk("t6_no_finish", 64'(n_fin - f0), 64'd0);
        chk("t6_no_desc", 64'(desc_valid), 64'd0);
        chk("t6_stats", 64'({stat_frames, stat_oversize}), 64'd0);
        send_frame(5, 1'b1, 8'h90, 4, 1'b1);
        wait_desc();
        send_frame(2, 1'b0, 8'hC0, 2, 1'b0);
        wait_desc();

        prt_start_slot = 0;
        wq.push_back(8'h55);
        wq.push_back(8'h56);
        send_word(8'h55, 0);
        s_valid = 1;
        s_data = 8'h56;
        @(negedge CLK);
        do_reset();
        repeat (3) @(negedge CLK);
        chk("t1_stats", 64'({stat_frames, stat_oversize}), 64'd0);
        send_frame(1, 1'b1, 8'hE0, 1, 1'b0);
        wait_desc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
